pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the VeSPA CPU pipeline. It replaces the fixed two-source forwarding and single-cycle stall logic with a configurable-depth forwarding selector, a counted multi-cycle load-use stall, and a sequenced interrupt entry with a non-nesting handler flag. It sits beside the datapath, reads decode, execute and later-stage register addresses, and drives the per-stage flush, stall and operand-forward selects.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/fwd_select.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the VeSPA pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL     = 2'd1,
        IRQ_ENTRY = 2'd2
    } hazard_state_e;

    localparam int FWD_SEL_RF = 0;

    // The counter holds at most load_lat-1; keep at least one bit so LOAD_LAT=1 still elaborates.
    function automatic int stall_cnt_width(input int load_lat);
        return (load_lat < 2) ? 1 : $clog2(load_lat);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one read port: youngest matching stage wins.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int  REG_ADDR_W  = 5,
    parameter int  NUM_FWD_SRC = 2,
    localparam int FWD_SEL_W   = $clog2(NUM_FWD_SRC + 1)
) (
    input  logic [REG_ADDR_W-1:0]             src,
    input  logic [NUM_FWD_SRC-1:0]            stg_we,
    input  logic [NUM_FWD_SRC*REG_ADDR_W-1:0] stg_dst,
    output logic [FWD_SEL_W-1:0]              sel
);

    // Scan oldest to youngest so the lowest matching index overrides.
    always_comb begin
        sel = FWD_SEL_W'(FWD_SEL_RF);
        for (int k = NUM_FWD_SRC - 1; k >= 0; k--) begin
            if (stg_we[k] && (stg_dst[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
                sel = FWD_SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: operand forwarding, counted load-use stall and
// non-nesting interrupt entry for the VeSPA pipeline.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  REG_ADDR_W   = 5,
    parameter int  NUM_RD_PORTS = 2,
    parameter int  NUM_FWD_SRC  = 2,
    parameter int  LOAD_LAT     = 1,
    localparam int FWD_SEL_W    = $clog2(NUM_FWD_SRC + 1)
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] i_DecSrc,
    input  logic [NUM_RD_PORTS-1:0]            i_DecSrcVld,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] i_ExSrc,
    input  logic [REG_ADDR_W-1:0]              i_ExDst,
    input  logic                               i_ExIsLoad,
    input  logic                               i_BranchTaken,
    input  logic                               i_Jmp,
    input  logic                               i_Reti,
    input  logic                               i_IrqReq,
    input  logic [NUM_FWD_SRC-1:0]             i_StgWe,
    input  logic [NUM_FWD_SRC*REG_ADDR_W-1:0]  i_StgDst,
    output logic [NUM_RD_PORTS*FWD_SEL_W-1:0]  o_FwdSel,
    output logic                               o_FlushFetch,
    output logic                               o_FlushDecode,
    output logic                               o_FlushExecute,
    output logic                               o_Stall,
    output logic                               o_IrqAck
);

    localparam int CNT_W = stall_cnt_width(LOAD_LAT);

    hazard_state_e               state;
    logic [CNT_W-1:0]            stall_cnt;
    logic                        irq_active;
    logic [NUM_RD_PORTS*FWD_SEL_W-1:0] fwd_raw;
    logic                        xfer;
    logic                        detect;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_fwd
        fwd_select #(
            .REG_ADDR_W  (REG_ADDR_W),
            .NUM_FWD_SRC (NUM_FWD_SRC)
        ) u_fwd_select (
            .src     (i_ExSrc[p*REG_ADDR_W +: REG_ADDR_W]),
            .stg_we  (i_StgWe),
            .stg_dst (i_StgDst),
            .sel     (fwd_raw[p*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    assign xfer = i_BranchTaken | i_Jmp | i_Reti;

    always_comb begin
        detect = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (i_DecSrcVld[p] && (i_DecSrc[p*REG_ADDR_W +: REG_ADDR_W] == i_ExDst)) begin
                detect = i_ExIsLoad;
            end
        end
    end

    // RUN-state controls are same-cycle; all outputs are held low during reset.
    always_comb begin
        o_FlushFetch   = 1'b0;
        o_FlushDecode  = 1'b0;
        o_FlushExecute = 1'b0;
        o_Stall        = 1'b0;
        o_IrqAck       = 1'b0;
        unique case (state)
            RUN: begin
                if (xfer) begin
                    o_FlushFetch  = 1'b1;
                    o_FlushDecode = 1'b1;
                end else if (detect) begin
                    o_Stall        = 1'b1;
                    o_FlushExecute = 1'b1;
                end
            end
            STALL: begin
                o_Stall        = 1'b1;
                o_FlushExecute = 1'b1;
                o_FlushFetch   = xfer;
                o_FlushDecode  = xfer;
            end
            IRQ_ENTRY: begin
                o_FlushFetch   = 1'b1;
                o_FlushDecode  = 1'b1;
                o_FlushExecute = 1'b1;
                o_IrqAck       = 1'b1;
            end
            default: ;
        endcase
        if (!i_Rst) begin
            o_FlushFetch   = 1'b0;
            o_FlushDecode  = 1'b0;
            o_FlushExecute = 1'b0;
            o_Stall        = 1'b0;
            o_IrqAck       = 1'b0;
        end
    end

    assign o_FwdSel = i_Rst ? fwd_raw : '0;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state      <= RUN;
            stall_cnt  <= '0;
            irq_active <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (xfer) begin
                        if (i_Reti) irq_active <= 1'b0;
                    end else if (detect) begin
                        if (LOAD_LAT > 1) begin
                            stall_cnt <= CNT_W'(LOAD_LAT - 1);
                            state     <= STALL;
                        end
                    end else if (i_IrqReq && !irq_active) begin
                        state <= IRQ_ENTRY;
                    end
                end
                STALL: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        state     <= RUN;
                        if (i_Reti) irq_active <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt - 1'b1;
                        if (stall_cnt <= CNT_W'(1)) state <= RUN;
                    end
                end
                IRQ_ENTRY: begin
                    irq_active <= 1'b1;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int W   = 5;
    localparam int NP  = 2;
    localparam int NS  = 3;
    localparam int LL  = 3;
    localparam int FSW = $clog2(NS + 1);

    typedef struct packed {
        logic            rst;
        logic [NP*W-1:0] dec_src;
        logic [NP-1:0]   dec_vld;
        logic [NP*W-1:0] ex_src;
        logic [W-1:0]    ex_dst;
        logic            ex_load;
        logic            bt;
        logic            jmp;
        logic            reti;
        logic            irq;
        logic [NS-1:0]   stg_we;
        logic [NS*W-1:0] stg_dst;
    } stim_t;

    typedef struct packed {
        logic [NP*FSW-1:0] fwd;
        logic              ff;
        logic              fd;
        logic              fe;
        logic              stall;
        logic              ack;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*W-1:0]   dec_src = '0;
    logic [NP-1:0]     dec_vld = '0;
    logic [NP*W-1:0]   ex_src = '0;
    logic [W-1:0]      ex_dst = '0;
    logic              ex_load = 1'b0;
    logic              bt = 1'b0;
    logic              jmp = 1'b0;
    logic              reti = 1'b0;
    logic              irq = 1'b0;
    logic [NS-1:0]     stg_we = '0;
    logic [NS*W-1:0]   stg_dst = '0;
    logic [NP*FSW-1:0] fwd_sel;
    logic              flush_f, flush_d, flush_e, stall, irq_ack;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Reference model state: remaining stall cycles, pending entry, handler running.
    int stall_left = 0;
    bit entry_now  = 1'b0;
    bit handler    = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (W),
        .NUM_RD_PORTS (NP),
        .NUM_FWD_SRC  (NS),
        .LOAD_LAT     (LL)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst_n),
        .i_DecSrc       (dec_src),
        .i_DecSrcVld    (dec_vld),
        .i_ExSrc        (ex_src),
        .i_ExDst        (ex_dst),
        .i_ExIsLoad     (ex_load),
        .i_BranchTaken  (bt),
        .i_Jmp          (jmp),
        .i_Reti         (reti),
        .i_IrqReq       (irq),
        .i_StgWe        (stg_we),
        .i_StgDst       (stg_dst),
        .o_FwdSel       (fwd_sel),
        .o_FlushFetch   (flush_f),
        .o_FlushDecode  (flush_d),
        .o_FlushExecute (flush_e),
        .o_Stall        (stall),
        .o_IrqAck       (irq_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Drive one cycle, predict the outputs for it and advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit   xfer, det, found;
        int   next_left;
        bit   next_entry, next_handler;
        @(posedge clk);
        #1;
        rst_n   = s.rst;
        dec_src = s.dec_src;
        dec_vld = s.dec_vld;
        ex_src  = s.ex_src;
        ex_dst  = s.ex_dst;
        ex_load = s.ex_load;
        bt      = s.bt;
        jmp     = s.jmp;
        reti    = s.reti;
        irq     = s.irq;
        stg_we  = s.stg_we;
        stg_dst = s.stg_dst;
        e = '0;
        if (!s.rst) begin
            stall_left = 0;
            entry_now  = 1'b0;
            handler    = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                found = 1'b0;
                for (int k = 0; k < NS; k++) begin
                    if (!found && s.stg_we[k] &&
                        s.stg_dst[k*W +: W] == s.ex_src[p*W +: W]) begin
                        e.fwd[p*FSW +: FSW] = FSW'(k + 1);
                        found = 1'b1;
                    end
                end
            end
            xfer = s.bt | s.jmp | s.reti;
            det  = 1'b0;
            for (int p = 0; p < NP; p++)
                if (s.ex_load && s.dec_vld[p] && s.dec_src[p*W +: W] == s.ex_dst) det = 1'b1;
            next_left    = 0;
            next_entry   = 1'b0;
            next_handler = handler;
            if (entry_now) begin
                {e.ff, e.fd, e.fe, e.ack} = 4'b1111;
                next_handler = 1'b1;
            end else if (stall_left > 0) begin
                e.stall = 1'b1;
                e.fe    = 1'b1;
                if (xfer) begin
                    e.ff = 1'b1;
                    e.fd = 1'b1;
                    if (s.reti) next_handler = 1'b0;
                end else begin
                    next_left = stall_left - 1;
                end
            end else if (xfer) begin
                e.ff = 1'b1;
                e.fd = 1'b1;
                if (s.reti) next_handler = 1'b0;
            end else if (det) begin
                e.stall   = 1'b1;
                e.fe      = 1'b1;
                next_left = LL - 1;
            end else if (s.irq && !handler) begin
                next_entry = 1'b1;
            end
            stall_left = next_left;
            entry_now  = next_entry;
            handler    = next_handler;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
                check("flush_fetch", 32'(flush_f), 32'(e.ff));
                check("flush_decode", 32'(flush_d), 32'(e.fd));
                check("flush_execute", 32'(flush_e), 32'(e.fe));
                check("stall", 32'(stall), 32'(e.stall));
                check("irq_ack", 32'(irq_ack), 32'(e.ack));
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        stim_t s;
        // Reset with active-looking inputs: every output must still be 0.
        s = idle();
        s.rst = 1'b0;
        s.bt = 1'b1;
        s.stg_we = 3'b111;
        step(s);
        step(s);
        // Forwarding priority and fallback to the register file.
        s = idle();
        s.ex_src[0 +: W] = 5'd7;
        s.stg_we = 3'b101;
        s.stg_dst[0 +: W] = 5'd7;
        s.stg_dst[2*W +: W] = 5'd7;
        step(s);
        s.stg_we = 3'b100;
        step(s);
        s.stg_dst[2*W +: W] = 5'd9;
        step(s);
        // Load-use stall runs LOAD_LAT cycles.
        s = idle();
        s.ex_load = 1'b1;
        s.ex_dst = 5'd4;
        s.dec_src[W +: W] = 5'd4;
        s.dec_vld = 2'b10;
        step(s);
        repeat (4) step(idle());
        // Branch in the second stall cycle aborts the stall.
        step(s);
        s = idle();
        s.bt = 1'b1;
        step(s);
        repeat (2) step(idle());
        // Held interrupt: a single ack, then none until reti.
        s = idle();
        s.irq = 1'b1;
        repeat (5) step(s);
        s.reti = 1'b1;
        step(s);
        s.reti = 1'b0;
        repeat (4) step(s);
        s.reti = 1'b1;
        s.irq = 1'b0;
        step(s);
        step(idle());
        // Reset in the middle of a stall.
        s = idle();
        s.ex_load = 1'b1;
        s.ex_dst = 5'd3;
        s.dec_src[0 +: W] = 5'd3;
        s.dec_vld = 2'b01;
        step(s);
        s = idle();
        s.rst = 1'b0;
        step(s);
        repeat (3) step(idle());
        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst     = ($urandom_range(0, 199) != 0);
            s.ex_load = $urandom_range(0, 1) == 1;
            s.ex_dst  = W'($urandom_range(0, 7));
            s.dec_vld = NP'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                s.dec_src[p*W +: W] = W'($urandom_range(0, 7));
                s.ex_src[p*W +: W]  = W'($urandom_range(0, 7));
            end
            for (int k = 0; k < NS; k++) s.stg_dst[k*W +: W] = W'($urandom_range(0, 7));
            s.stg_we = NS'($urandom_range(0, 7));
            s.bt     = $urandom_range(0, 15) == 0;
            s.jmp    = $urandom_range(0, 15) == 0;
            s.reti   = $urandom_range(0, 31) == 0;
            s.irq    = $urandom_range(0, 3) == 0;
            step(s);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
